// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg
// Shared definitions for the SPI command decoder: opcodes, reply tags,
// register address width and the decoder FSM state type.
package spi_cmd_pkg;

    localparam int unsigned ADDR_W = 4;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_WRITE  = 8'h10;
    localparam logic [7:0] OP_READ   = 8'h20;
    localparam logic [7:0] OP_STATUS = 8'hFE;
    localparam logic [7:0] OP_ERRCLR = 8'hFD;

    localparam logic [7:0] ACK = 8'hA5;
    localparam logic [7:0] ERR = 8'hEE;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WDATA = 1'b1
    } cmd_state_t;

endpackage

// File: rtl/spi_cmd_regfile.sv
// spi_cmd_regfile
// NUM_REGS x 64-bit configuration register bank with a single write port.
// Ports:
//   clk, resetn     clock, synchronous active-low reset
//   i_we            write enable
//   i_waddr         write address
//   i_wdata         write data
//   o_regs_flat     all registers, reg i at [64*i+63:64*i]
//   o_wr_strobe     one-cycle pulse on bit i, coincident with reg i update
module spi_cmd_regfile
    import spi_cmd_pkg::*;
#(
    parameter int NUM_REGS = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     i_we,
    input  logic [ADDR_W-1:0]        i_waddr,
    input  logic [63:0]              i_wdata,
    output logic [64*NUM_REGS-1:0]   o_regs_flat,
    output logic [NUM_REGS-1:0]      o_wr_strobe
);

    logic [63:0]         r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_wr_strobe;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wr_strobe <= '0;
        end else begin
            r_wr_strobe <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (i_we && (i_waddr == ADDR_W'(i))) begin
                    r_regs[i]      <= i_wdata;
                    r_wr_strobe[i] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_regs_flat = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            o_regs_flat[64*i +: 64] = r_regs[i];
        end
    end

    assign o_wr_strobe = r_wr_strobe;

endmodule

// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder
// Decodes 64-bit SPI words into register writes/reads and status replies.
// Optional feature macro: SPI_CMD_ERRCNT_EN (8-bit saturating error counter,
// reported in STATUS[23:16], cleared by opcode 8'hFD).
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   cs_n                 raw SPI chip select (async, active low)
//   word_received        high while the current 64-bit word is complete
//   word_data_received   received word
//   word_send_data       reply word for the next transfer
//   regs_flat            register bank, reg i at [64*i+63:64*i]
//   wr_strobe            one-cycle pulse per written register
//   cmd_error            one-cycle pulse on bad opcode/address
module spi_cmd_decoder
    import spi_cmd_pkg::*;
#(
    parameter int          NUM_REGS = 8,
    parameter logic [15:0] VERSION  = 16'h0001
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     cs_n,
    input  logic                     word_received,
    input  logic [63:0]              word_data_received,
    output logic [63:0]              word_send_data,
    output logic [64*NUM_REGS-1:0]   regs_flat,
    output logic [NUM_REGS-1:0]      wr_strobe,
    output logic                     cmd_error
);

    cmd_state_t        r_state;
    logic [1:0]        r_cs_sync;
    logic              r_word_received_d;
    logic [ADDR_W-1:0] r_waddr;
    logic [63:0]       r_send_data;
    logic              r_cmd_error;
    logic [7:0]        w_errcnt;

    logic              w_cs_active;
    logic              w_event;
    logic [7:0]        w_op;
    logic [ADDR_W-1:0] w_addr;
    logic              w_addr_ok;
    logic              w_we;
    logic [63:0]       w_rd_data;

    assign w_cs_active = ~r_cs_sync[1];
    assign w_event     = word_received & ~r_word_received_d & w_cs_active;
    assign w_op        = word_data_received[63:56];
    assign w_addr      = word_data_received[51:48];
    assign w_addr_ok   = int'(w_addr) < NUM_REGS;
    // The regfile is written on the same edge the FSM leaves WDATA so the
    // register, strobe and reply all change together.
    assign w_we        = w_event && (r_state == ST_WDATA);

    always_comb begin
        w_rd_data = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (w_addr == ADDR_W'(i)) begin
                w_rd_data = regs_flat[64*i +: 64];
            end
        end
    end

`ifdef SPI_CMD_ERRCNT_EN
    logic [7:0] r_errcnt;
    assign w_errcnt = r_errcnt;
`else
    assign w_errcnt = 8'h00;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state           <= ST_IDLE;
            r_cs_sync         <= 2'b11;
            r_word_received_d <= 1'b0;
            r_waddr           <= '0;
            r_send_data       <= '0;
            r_cmd_error       <= 1'b0;
`ifdef SPI_CMD_ERRCNT_EN
            r_errcnt          <= '0;
`endif
        end else begin
            r_cs_sync         <= {r_cs_sync[0], cs_n};
            r_word_received_d <= word_received;
            r_cmd_error       <= 1'b0;

            if (!w_cs_active) begin
                r_state <= ST_IDLE;
            end else if (w_event) begin
                case (r_state)
                    ST_WDATA: begin
                        r_send_data <= {ACK, OP_WRITE, 44'h0, r_waddr};
                        r_state     <= ST_IDLE;
                    end
                    default: begin
                        case (w_op)
                            OP_NOP: ;
                            OP_WRITE: begin
                                if (w_addr_ok) begin
                                    r_waddr <= w_addr;
                                    r_state <= ST_WDATA;
                                end else begin
                                    r_cmd_error <= 1'b1;
                                    r_send_data <= {ERR, w_op, 48'h0};
`ifdef SPI_CMD_ERRCNT_EN
                                    if (r_errcnt != 8'hFF) r_errcnt <= r_errcnt + 8'd1;
`endif
                                end
                            end
                            OP_READ: begin
                                if (w_addr_ok) begin
                                    r_send_data <= w_rd_data;
                                end else begin
                                    r_cmd_error <= 1'b1;
                                    r_send_data <= {ERR, w_op, 48'h0};
`ifdef SPI_CMD_ERRCNT_EN
                                    if (r_errcnt != 8'hFF) r_errcnt <= r_errcnt + 8'd1;
`endif
                                end
                            end
                            OP_STATUS: begin
                                r_send_data <= {OP_STATUS, 8'h00, VERSION, 8'(NUM_REGS), w_errcnt, 16'h0};
                            end
`ifdef SPI_CMD_ERRCNT_EN
                            OP_ERRCLR: begin
                                r_errcnt    <= '0;
                                r_send_data <= {ACK, OP_ERRCLR, 48'h0};
                            end
`endif
                            default: begin
                                r_cmd_error <= 1'b1;
                                r_send_data <= {ERR, w_op, 48'h0};
`ifdef SPI_CMD_ERRCNT_EN
                                if (r_errcnt != 8'hFF) r_errcnt <= r_errcnt + 8'd1;
`endif
                            end
                        endcase
                    end
                endcase
            end
        end
    end

    spi_cmd_regfile #(
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk         (clk),
        .resetn      (resetn),
        .i_we        (w_we),
        .i_waddr     (r_waddr),
        .i_wdata     (word_data_received),
        .o_regs_flat (regs_flat),
        .o_wr_strobe (wr_strobe)
    );

    assign word_send_data = r_send_data;
    assign cmd_error      = r_cmd_error;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// tb_spi_cmd_decoder
// Directed stimulus with a word-level reference model of the decoder; every
// cycle the DUT outputs are compared against the model, and a few literal
// expectations pin the model itself.
module tb_spi_cmd_decoder;

    localparam int          N   = 8;
    localparam logic [15:0] VER = 16'h0001;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              cs_n = 1'b0;
    logic              word_received = 1'b0;
    logic [63:0]       word_data_received = '0;
    logic [63:0]       word_send_data;
    logic [64*N-1:0]   regs_flat;
    logic [N-1:0]      wr_strobe;
    logic              cmd_error;

    spi_cmd_decoder #(
        .NUM_REGS (N),
        .VERSION  (VER)
    ) dut (
        .clk                (clk),
        .resetn             (resetn),
        .cs_n               (cs_n),
        .word_received      (word_received),
        .word_data_received (word_data_received),
        .word_send_data     (word_send_data),
        .regs_flat          (regs_flat),
        .wr_strobe          (wr_strobe),
        .cmd_error          (cmd_error)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [63:0] m_regs [N];
    logic [63:0] exp_reply;
    logic [N-1:0] exp_strobe;
    logic        exp_err;
    bit          m_pending;
    int          m_paddr;
    bit          m_cs_active;
    logic [7:0]  m_errcnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    logic [N-1:0] last_strobe;
    logic         last_err;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [64*N-1:0] model_flat();
        logic [64*N-1:0] f;
        for (int i = 0; i < N; i++) f[64*i +: 64] = m_regs[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_regs[i] = '0;
        exp_reply  = '0;
        exp_strobe = '0;
        exp_err    = 1'b0;
        m_pending  = 1'b0;
        m_paddr    = 0;
        m_errcnt   = '0;
    endtask

    // Effect of one accepted word, derived directly from the command rules.
    task automatic model_apply(input logic [63:0] d);
        logic [7:0] op;
        int         a;
        op = d[63:56];
        a  = int'(d[51:48]);
        exp_strobe = '0;
        exp_err    = 1'b0;
        if (!m_cs_active) return;
        if (m_pending) begin
            m_regs[m_paddr]     = d;
            exp_strobe[m_paddr] = 1'b1;
            exp_reply           = {8'hA5, 8'h10, 44'h0, 4'(m_paddr)};
            m_pending           = 1'b0;
        end else if (op == 8'h00) begin
        end else if (op == 8'h10 && a < N) begin
            m_pending = 1'b1;
            m_paddr   = a;
        end else if (op == 8'h20 && a < N) begin
            exp_reply = m_regs[a];
        end else if (op == 8'hFE) begin
            exp_reply = {8'hFE, 8'h00, VER, 8'(N), m_errcnt, 16'h0};
`ifdef SPI_CMD_ERRCNT_EN
        end else if (op == 8'hFD) begin
            m_errcnt  = '0;
            exp_reply = {8'hA5, 8'hFD, 48'h0};
`endif
        end else begin
            exp_err   = 1'b1;
            exp_reply = {8'hEE, op, 48'h0};
`ifdef SPI_CMD_ERRCNT_EN
            if (m_errcnt != 8'hFF) m_errcnt = m_errcnt + 8'd1;
`endif
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (check_en) begin
            chk("regs_flat", 512'(regs_flat), 512'(model_flat()));
            chk("word_send_data", 512'(word_send_data), 512'(exp_reply));
            chk("wr_strobe", 512'(wr_strobe), 512'(exp_strobe));
            chk("cmd_error", 512'(cmd_error), 512'(exp_err));
        end
    end

    // Present one word, hold it for 'hold' cycles, then leave an idle gap.
    task automatic send_word(input logic [63:0] d, input int hold);
        @(negedge clk);
        word_data_received = d;
        word_received      = 1'b1;
        @(posedge clk);
        #1;
        model_apply(d);
        last_strobe = wr_strobe;
        last_err    = cmd_error;
        @(posedge clk);
        #1;
        exp_strobe = '0;
        exp_err    = 1'b0;
        repeat (hold - 1) @(posedge clk);
        @(negedge clk);
        word_received = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic set_cs(input logic v);
        @(negedge clk);
        cs_n = v;
        repeat (3) @(posedge clk);
        #1;
        m_cs_active = ~v;
        if (v) m_pending = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        model_reset();
        m_cs_active = 1'b1;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_en = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        chk("reset_reply", 512'(word_send_data), 512'(64'h0));

        // STATUS
        send_word(64'hFE00_0000_0000_0000, 1);
        chk("status_lit", 512'(word_send_data), 512'(64'hFE00_0001_0800_0000));
        chk("status_nostrobe", 512'(last_strobe), 512'(8'h00));

        // WRITE reg3
        send_word(64'h1003_0000_0000_0000, 1);
        send_word(64'h0123_4567_89AB_CDEF, 1);
        chk("write_reg3", 512'(regs_flat[64*3 +: 64]), 512'(64'h0123_4567_89AB_CDEF));
        chk("write_strobe", 512'(last_strobe), 512'(8'b0000_1000));
        chk("write_reply", 512'(word_send_data), 512'(64'hA510_0000_0000_0003));

        // READ reg3 held for 50 cycles
        send_word(64'h2003_0000_0000_0000, 50);
        chk("read_reply", 512'(word_send_data), 512'(64'h0123_4567_89AB_CDEF));

        // Held bad opcode: only one error pulse (per-cycle compare catches more)
        send_word(64'h7700_0000_0000_0000, 10);
        chk("badop_err", 512'(last_err), 512'(1'b1));

        // WRITE to out-of-range addr 9, next word is a header
        send_word(64'h1009_0000_0000_0000, 1);
        chk("addr9_err", 512'(last_err), 512'(1'b1));
        chk("addr9_reply", 512'(word_send_data), 512'(64'hEE10_0000_0000_0000));
        send_word(64'hFE00_0000_0000_0000, 1);
        chk("after_err_status", 512'(word_send_data), 512'(64'hFE00_0001_0800_0000));

        // READ to out-of-range address
        send_word(64'h200F_0000_0000_0000, 1);
        chk("read_oob_reply", 512'(word_send_data), 512'(64'hEE20_0000_0000_0000));

        // Payload 8'h20 is data, not a read; also writes top register
        send_word(64'h1001_0000_0000_0000, 1);
        send_word(64'h2003_0000_0000_0000, 1);
        chk("payload_is_data", 512'(regs_flat[64*1 +: 64]), 512'(64'h2003_0000_0000_0000));
        send_word(64'h1007_0000_0000_0000, 1);
        send_word(64'hDEAD_BEEF_CAFE_F00D, 1);
        chk("write_reg7_reply", 512'(word_send_data), 512'(64'hA510_0000_0000_0007));

        // CS deassert discards pending write
        send_word(64'h1005_0000_0000_0000, 1);
        send_word(64'h5555_AAAA_5555_AAAA, 1);
        send_word(64'h1005_0000_0000_0000, 1);
        set_cs(1'b1);
        set_cs(1'b0);
        send_word(64'h0000_0000_0000_0000, 1);
        chk("cs_discard_reg5", 512'(regs_flat[64*5 +: 64]), 512'(64'h5555_AAAA_5555_AAAA));
        chk("cs_discard_strobe", 512'(last_strobe), 512'(8'h00));

        // Words while CS inactive are ignored
        set_cs(1'b1);
        send_word(64'h7700_0000_0000_0000, 1);
        chk("cs_inactive_noerr", 512'(last_err), 512'(1'b0));
        set_cs(1'b0);

`ifdef SPI_CMD_ERRCNT_EN
        for (int i = 0; i < 300; i++) send_word(64'h7700_0000_0000_0000, 1);
        send_word(64'hFE00_0000_0000_0000, 1);
        chk("errcnt_sat", 512'(word_send_data[23:16]), 512'(8'hFF));
        send_word(64'hFD00_0000_0000_0000, 1);
        chk("errclr_reply", 512'(word_send_data), 512'(64'hA5FD_0000_0000_0000));
        send_word(64'hFE00_0000_0000_0000, 1);
        chk("errcnt_cleared", 512'(word_send_data[23:16]), 512'(8'h00));
`else
        send_word(64'hFD00_0000_0000_0000, 1);
        chk("fd_is_bad", 512'(word_send_data), 512'(64'hEEFD_0000_0000_0000));
`endif

        // Reset in the middle of a write command
        send_word(64'h1002_0000_0000_0000, 1);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        chk("midreset_regs", 512'(regs_flat), 512'(0));
        send_word(64'h1234_5678_9ABC_DEF0, 1);
        chk("midreset_nowrite", 512'(regs_flat[64*2 +: 64]), 512'(64'h0));

        repeat (2) @(negedge clk);
        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
